pkt_tx: RTL
===========

PKT_TX -- requirements
Module: pkt_tx

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: port clock is the sole clock; reset is sampled only on posedge clock.
REQ-002 Parameter DATA_W, default 8, payload word width.
REQ-003 Parameter LEN_W, default 4, packet length field width (max packet 2^LEN_W-1 words).
REQ-004 clock  in  1  rising-edge clock.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 start  in  1  packet request; sampled only in IDLE.
REQ-007 length  in  LEN_W  packet word count, legal 2..2^LEN_W-1; sampled with start.
REQ-008 src_valid  in  1  source word available.
REQ-009 src_data  in  DATA_W  source word.
REQ-010 src_ready  out  1  block accepts src_data this cycle.
REQ-011 valid  out  1  output word present.
REQ-012 head  out  1  output word is first of packet.
REQ-013 tail  out  1  output word is last of packet.
REQ-014 data  out  DATA_W  output word.
REQ-015 ready  in  1  downstream accepts output word this cycle.
REQ-016 busy  out  1  state != IDLE.
REQ-017 err  out  1  one-cycle pulse: start with illegal length.

Function
REQ-018 SHALL hold a 2-bit state: IDLE=2'b00, HEAD=2'b01, DATA=2'b10, TAIL=2'b11 (state denotes the word being fetched).
REQ-019 IDLE: start & length>=2 -> HEAD, rem<=length; start & length<2 -> stay IDLE, err=1 next cycle only.
REQ-020 Source handshake = src_valid & src_ready; src_ready = (state!=IDLE) & rem!=0 & (!valid | ready), combinational.
REQ-021 On source handshake: data<=src_data, valid<=1, head<=(state==HEAD), tail<=(rem==1), rem<=rem-1.
REQ-022 HEAD -> DATA on handshake if rem>2, -> TAIL if rem==2; DATA -> TAIL on handshake when rem==2.
REQ-023 TAIL: after last fetch src_ready=0; -> IDLE on cycle where valid & tail & ready.
REQ-024 Output accepted (valid & ready) with no new handshake: valid, head, tail <=0; data unchanged.
REQ-025 valid & !ready: data, head, tail held stable until accepted (no change, no drop).
REQ-026 Accept and load in same cycle SHALL give back-to-back words: one word/cycle with ready and src_valid held high.
REQ-027 Latency: start at edge N -> src_ready high during cycle N+1 -> first word (head=1) valid from N+2.
REQ-028 head and tail SHALL never assert together; exactly one head and one tail per packet; exactly length words with valid.
REQ-029 start while busy SHALL be ignored (no err, no effect); start in the cycle state returns to IDLE is ignored.
REQ-030 src_valid low mid-packet: valid drops once current word accepted; framing resumes with next word, no duplicate head.

Reset
REQ-031 reset SHALL force state=IDLE, rem=0, valid=head=tail=err=0, src_ready=0, busy=0, data=0 on next edge; overrides all other inputs.
REQ-032 Reset mid-packet SHALL abandon the packet: no tail emitted, next start begins fresh with head.

Structure
REQ-033 Package pkt_pkg SHALL hold STATE_IDLE/HEAD/DATA/TAIL encodings and DATA_W/LEN_W defaults, shared with the packet receiver FSM.
REQ-034 Single module; no sub-module required (output register inline).

Verification
REQ-035 length=4, src_valid=1, ready=1: words D0..D3 on consecutive cycles, head with D0 only, tail with D3 only, busy falls cycle after D3.
REQ-036 length=2: exactly two valid words, head on first, tail on second, state HEAD->TAIL->IDLE, DATA never entered.
REQ-037 length=1 and length=0: err pulses one cycle, no valid, busy stays 0.
REQ-038 length=5, ready low 3 cycles at word 2: word 2 data/head/tail held stable, src_ready=0, packet completes with 5 words in order.
REQ-039 length=6, reset asserted after word 3 accepted: all outputs 0 next cycle, no tail; new start length=3 yields head/data/tail cleanly.
REQ-040 Stream into a receiver-side FSM (IDLE/HEAD/DATA/TAIL): every transition observed legal and all four states reached.

Source files
------------

// File: rtl/pkt_pkg.sv
// Shared packet framing definitions for the transmit and receive FSMs.
package pkt_pkg;

  localparam int PKT_DATA_W = 8;
  localparam int PKT_LEN_W  = 4;

  // State names the word currently being fetched (or the idle gap between packets).
  typedef enum logic [1:0] {
    STATE_IDLE = 2'b00,
    STATE_HEAD = 2'b01,
    STATE_DATA = 2'b10,
    STATE_TAIL = 2'b11
  } pkt_state_e;

endpackage

// File: rtl/pkt_tx.sv
// Packet transmitter: frames a requested number of source words into a
// head/data/tail stream through a single output register with full
// back-pressure and one word per cycle throughput.
module pkt_tx
  import pkt_pkg::*;
#(
  parameter int DATA_W = PKT_DATA_W,
  parameter int LEN_W  = PKT_LEN_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  length,
  input  logic              src_valid,
  input  logic [DATA_W-1:0] src_data,
  output logic              src_ready,
  output logic              valid,
  output logic              head,
  output logic              tail,
  output logic [DATA_W-1:0] data,
  input  logic              ready,
  output logic              busy,
  output logic              err
);

  localparam logic [LEN_W-1:0] REM_ONE = LEN_W'(1);
  localparam logic [LEN_W-1:0] REM_TWO = LEN_W'(2);

  pkt_state_e        state_reg;
  logic [LEN_W-1:0]  rem_reg;
  logic [DATA_W-1:0] data_reg;
  logic              valid_reg;
  logic              head_reg;
  logic              tail_reg;
  logic              err_reg;
  logic              src_fire;
  logic              out_fire;

  // Fetch only while a packet is open, words remain, and the output slot is empty or draining now.
  always_comb begin
    src_ready = (state_reg != STATE_IDLE) && (rem_reg != '0) && (!valid_reg || ready);
    src_fire  = src_valid && src_ready;
    out_fire  = valid_reg && ready;
  end

  // Packet FSM and output register; a load in the same cycle as an accept overrides the clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= STATE_IDLE;
      rem_reg   <= '0;
      data_reg  <= '0;
      valid_reg <= 1'b0;
      head_reg  <= 1'b0;
      tail_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      err_reg <= 1'b0;

      if (out_fire) begin
        valid_reg <= 1'b0;
        head_reg  <= 1'b0;
        tail_reg  <= 1'b0;
      end

      if (src_fire) begin
        data_reg  <= src_data;
        valid_reg <= 1'b1;
        head_reg  <= (state_reg == STATE_HEAD);
        tail_reg  <= (rem_reg == REM_ONE);
        rem_reg   <= rem_reg - REM_ONE;
      end

      case (state_reg)
        STATE_IDLE: begin
          if (start) begin
            if (length >= REM_TWO) begin
              state_reg <= STATE_HEAD;
              rem_reg   <= length;
            end else begin
              err_reg <= 1'b1;
            end
          end
        end
        STATE_HEAD: begin
          if (src_fire) begin
            state_reg <= (rem_reg > REM_TWO) ? STATE_DATA : STATE_TAIL;
          end
        end
        STATE_DATA: begin
          if (src_fire && (rem_reg == REM_TWO)) begin
            state_reg <= STATE_TAIL;
          end
        end
        STATE_TAIL: begin
          if (valid_reg && tail_reg && ready) begin
            state_reg <= STATE_IDLE;
          end
        end
        default: state_reg <= STATE_IDLE;
      endcase
    end
  end

  assign valid = valid_reg;
  assign head  = head_reg;
  assign tail  = tail_reg;
  assign data  = data_reg;
  assign busy  = (state_reg != STATE_IDLE);
  assign err   = err_reg;

endmodule
